// File: rtl/roam_pkg.sv
// Shared encodings for the roaming-mode sequencer and the motion decision mux.
package roam_pkg;

    localparam logic [1:0] MUX_PAUSE  = 2'b00;
    localparam logic [1:0] MUX_SPIRAL = 2'b01;
    localparam logic [1:0] MUX_RAND   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SPIRAL = 3'd2,
        ST_TURN   = 3'd3,
        ST_RAND   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // TURN and RAND both drive the random-motion path; everything else is paused.
    function automatic logic [1:0] state_mux(input state_t s);
        case (s)
            ST_SPIRAL:       state_mux = MUX_SPIRAL;
            ST_TURN, ST_RAND: state_mux = MUX_RAND;
            default:         state_mux = MUX_PAUSE;
        endcase
    endfunction

endpackage

// File: rtl/roam_tick_counter.sv
// Tick-gated up-counter with synchronous clear and a terminal-count match flag.
module roam_tick_counter #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic match
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/roam_mode_sequencer.sv
// Roaming behaviour FSM: selects pause/spiral/random motion, with a settle pause
// between every mode change, and strobes the motion generators on mode entry.
module roam_mode_sequencer
    import roam_pkg::*;
#(
    parameter int PAUSE_TICKS   = 4,
    parameter int RAND_TICKS    = 200,
    parameter int RAND_SEGMENTS = 3,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       bump,
    input  logic       cliff,
    input  logic       spiral_done,
    input  logic       turn_done,
    output logic [1:0] move_type_mux,
    output logic       spiral_start,
    output logic       rand_start,
    output logic       busy,
    output logic       fault
);

    localparam int SEG_W = (RAND_SEGMENTS > 1) ? $clog2(RAND_SEGMENTS) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(RAND_SEGMENTS - 1);

    state_t           state_q, state_d;
    state_t           next_mode_q, next_mode_d;
    logic [SEG_W-1:0] seg_cnt_q, seg_cnt_d;
    logic [1:0]       mux_q, mux_d;
    logic             spiral_start_q, spiral_start_d;
    logic             rand_start_q, rand_start_d;
    logic             busy_q, busy_d;
    logic             fault_q, fault_d;

    logic state_change;
    logic pause_match, rand_match;
    logic pause_done, rand_done;
    logic [SEG_W-1:0] seg_next;

    // Counters restart whenever the state moves, so each timed state starts from zero.
    assign state_change = (state_d != state_q);

    roam_tick_counter #(.CNT_W(CNT_W), .LIMIT(PAUSE_TICKS)) u_pause_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_change),
        .inc   (tick_en && (state_q == ST_SETTLE)),
        .match (pause_match)
    );

    roam_tick_counter #(.CNT_W(CNT_W), .LIMIT(RAND_TICKS)) u_rand_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_change),
        .inc   (tick_en && (state_q == ST_RAND)),
        .match (rand_match)
    );

    assign pause_done = tick_en && pause_match;
    assign rand_done  = tick_en && rand_match;
    assign seg_next   = (seg_cnt_q == SEG_LAST) ? seg_cnt_q : seg_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        next_mode_d = next_mode_q;
        seg_cnt_d   = seg_cnt_q;
        case (state_q)
            ST_IDLE, ST_FAULT: begin
                if (stop_btn) begin
                    state_d = ST_IDLE;
                end else if (start_btn && !cliff) begin
                    state_d     = ST_SETTLE;
                    next_mode_d = ST_SPIRAL;
                    seg_cnt_d   = '0;
                end else if (start_btn && (state_q == ST_IDLE)) begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                if (cliff) begin
                    state_d = ST_FAULT;
                end else if (stop_btn) begin
                    state_d = ST_IDLE;
                end else begin
                    case (state_q)
                        ST_SETTLE: begin
                            if (pause_done) state_d = next_mode_q;
                        end
                        ST_SPIRAL: begin
                            if (bump || spiral_done) begin
                                state_d     = ST_SETTLE;
                                next_mode_d = ST_TURN;
                                seg_cnt_d   = '0;
                            end
                        end
                        ST_TURN: begin
                            if (bump) begin
                                state_d     = ST_SETTLE;
                                next_mode_d = ST_TURN;
                            end else if (turn_done) begin
                                state_d = ST_RAND;
                            end
                        end
                        ST_RAND: begin
                            // A bump always leads to another turn; only expiry on the last segment returns to spiral.
                            if (bump || (rand_done && (seg_cnt_q != SEG_LAST))) begin
                                state_d     = ST_SETTLE;
                                next_mode_d = ST_TURN;
                                seg_cnt_d   = seg_next;
                            end else if (rand_done) begin
                                state_d     = ST_SETTLE;
                                next_mode_d = ST_SPIRAL;
                                seg_cnt_d   = '0;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        mux_d          = state_mux(state_d);
        spiral_start_d = (state_d == ST_SPIRAL) && (state_q != ST_SPIRAL);
        rand_start_d   = (state_d == ST_TURN) && (state_q != ST_TURN);
        busy_d         = (state_d != ST_IDLE) && (state_d != ST_FAULT);
        fault_d        = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            next_mode_q    <= ST_SPIRAL;
            seg_cnt_q      <= '0;
            mux_q          <= MUX_PAUSE;
            spiral_start_q <= 1'b0;
            rand_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            next_mode_q    <= next_mode_d;
            seg_cnt_q      <= seg_cnt_d;
            mux_q          <= mux_d;
            spiral_start_q <= spiral_start_d;
            rand_start_q   <= rand_start_d;
            busy_q         <= busy_d;
            fault_q        <= fault_d;
        end
    end

    assign move_type_mux = mux_q;
    assign spiral_start  = spiral_start_q;
    assign rand_start    = rand_start_q;
    assign busy          = busy_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_roam_mode_sequencer.sv
// Self-checking bench for roam_mode_sequencer: vector table plus hand-built
// long sequences, expected outputs flow through a scoreboard queue.
module tb_roam_mode_sequencer;

    // Input vector bits: {tick, start, stop, bump, cliff, spiral_done, turn_done}
    localparam logic [6:0] I_NONE  = 7'b0000000;
    localparam logic [6:0] I_TICK  = 7'b1000000;
    localparam logic [6:0] I_START = 7'b0100000;
    localparam logic [6:0] I_STOP  = 7'b0010000;
    localparam logic [6:0] I_BUMP  = 7'b0001000;
    localparam logic [6:0] I_CLIFF = 7'b0000100;
    localparam logic [6:0] I_SDONE = 7'b0000010;
    localparam logic [6:0] I_TDONE = 7'b0000001;

    // Expected output bits: {mux[1:0], spiral_start, rand_start, busy, fault}
    localparam logic [5:0] E_IDLE   = 6'b00_0_0_0_0;
    localparam logic [5:0] E_SETTLE = 6'b00_0_0_1_0;
    localparam logic [5:0] E_SPST   = 6'b01_1_0_1_0;
    localparam logic [5:0] E_SP     = 6'b01_0_0_1_0;
    localparam logic [5:0] E_TUST   = 6'b10_0_1_1_0;
    localparam logic [5:0] E_RND    = 6'b10_0_0_1_0;
    localparam logic [5:0] E_FAULT  = 6'b00_0_0_0_1;

    typedef struct {
        logic [6:0] stim;
        logic [5:0] want;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_en = 1'b0, start_btn = 1'b0, stop_btn = 1'b0, bump = 1'b0;
    logic       cliff = 1'b0, spiral_done = 1'b0, turn_done = 1'b0;
    logic [1:0] move_type_mux;
    logic       spiral_start, rand_start, busy, fault;

    int         total = 0;
    int         bad = 0;
    logic [5:0] exp_q[$];
    vec_t       vecs[$];

    roam_mode_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tick_en      (tick_en),
        .start_btn    (start_btn),
        .stop_btn     (stop_btn),
        .bump         (bump),
        .cliff        (cliff),
        .spiral_done  (spiral_done),
        .turn_done    (turn_done),
        .move_type_mux(move_type_mux),
        .spiral_start (spiral_start),
        .rand_start   (rand_start),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // The mux must never carry the unused 11 code while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (move_type_mux == 2'b11) begin
                bad++;
                $display("[TB] FAIL mux_never_11: got mux=%b, want not 11", move_type_mux);
            end
        end
    end

    task automatic check_output(input string name, input logic [5:0] want);
        logic [5:0] got;
        got = {move_type_mux, spiral_start, rand_start, busy, fault};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got {mux,ss,rs,busy,fault}=%b, want %b", name, got, want);
        end
    endtask

    task automatic apply_stimulus(input logic [6:0] stim, input logic [5:0] want, input string name);
        {tick_en, start_btn, stop_btn, bump, cliff, spiral_done, turn_done} = stim;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        check_output(name, exp_q.pop_front());
    endtask

    task automatic pause_into(input logic [5:0] want_final, input string name);
        repeat (3) apply_stimulus(I_TICK, E_SETTLE, "pause");
        apply_stimulus(I_TICK, want_final, name);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(I_TICK, E_RND, "rand_run");
    endtask

    initial begin
        vecs.push_back('{I_NONE,         E_IDLE,   "idle_quiet"});
        vecs.push_back('{I_TICK,         E_IDLE,   "idle_tick"});
        vecs.push_back('{I_BUMP,         E_IDLE,   "idle_bump"});
        vecs.push_back('{I_START,        E_SETTLE, "start"});
        vecs.push_back('{I_BUMP,         E_SETTLE, "settle_bump"});
        vecs.push_back('{I_TICK,         E_SETTLE, "pause1"});
        vecs.push_back('{I_NONE,         E_SETTLE, "no_tick_hold"});
        vecs.push_back('{I_TICK|I_BUMP,  E_SETTLE, "pause2_bump"});
        vecs.push_back('{I_TICK,         E_SETTLE, "pause3"});
        vecs.push_back('{I_TICK,         E_SPST,   "enter_spiral"});
        vecs.push_back('{I_NONE,         E_SP,     "spiral_hold"});
        vecs.push_back('{I_TICK,         E_SP,     "spiral_tick"});
        vecs.push_back('{I_BUMP,         E_SETTLE, "spiral_bump"});
        vecs.push_back('{I_TICK,         E_SETTLE, "p1"});
        vecs.push_back('{I_TICK,         E_SETTLE, "p2"});
        vecs.push_back('{I_TICK,         E_SETTLE, "p3"});
        vecs.push_back('{I_TICK,         E_TUST,   "enter_turn"});
        vecs.push_back('{I_NONE,         E_RND,    "turn_hold"});
        vecs.push_back('{I_BUMP,         E_SETTLE, "turn_bump"});
        vecs.push_back('{I_TICK,         E_SETTLE, "p1"});
        vecs.push_back('{I_TICK,         E_SETTLE, "p2"});
        vecs.push_back('{I_TICK,         E_SETTLE, "p3"});
        vecs.push_back('{I_TICK,         E_TUST,   "reenter_turn"});
        vecs.push_back('{I_TDONE,        E_RND,    "enter_rand"});

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", E_IDLE);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].stim, vecs[i].want, vecs[i].name);
        end

        // Three full random segments: two back to TURN, the third back to SPIRAL.
        rand_run(199);
        apply_stimulus(I_TICK, E_SETTLE, "rand_expire1");
        pause_into(E_TUST, "seg1_turn");
        apply_stimulus(I_TDONE, E_RND, "enter_rand");
        rand_run(199);
        apply_stimulus(I_TICK, E_SETTLE, "rand_expire2");
        pause_into(E_TUST, "seg2_turn");
        apply_stimulus(I_TDONE, E_RND, "enter_rand");
        rand_run(199);
        apply_stimulus(I_TICK, E_SETTLE, "rand_expire3");
        pause_into(E_SPST, "seg3_spiral");

        // Walk seg_cnt up to its last value with bumps, then collide bump with expiry.
        apply_stimulus(I_BUMP, E_SETTLE, "spiral_bump");
        pause_into(E_TUST, "turn");
        apply_stimulus(I_TDONE, E_RND, "enter_rand");
        apply_stimulus(I_BUMP, E_SETTLE, "rand_bump1");
        pause_into(E_TUST, "turn");
        apply_stimulus(I_TDONE, E_RND, "enter_rand");
        apply_stimulus(I_BUMP, E_SETTLE, "rand_bump2");
        pause_into(E_TUST, "turn");
        apply_stimulus(I_TDONE, E_RND, "enter_rand");
        rand_run(199);
        apply_stimulus(I_TICK|I_BUMP, E_SETTLE, "bump_with_expiry");
        pause_into(E_TUST, "bump_wins_turn");
        apply_stimulus(I_TDONE, E_RND, "enter_rand");
        rand_run(199);
        apply_stimulus(I_TICK, E_SETTLE, "sat_expiry");
        pause_into(E_SPST, "sat_expiry_spiral");

        // Fault handling and simultaneous-event priorities.
        apply_stimulus(I_CLIFF|I_BUMP,   E_FAULT,  "cliff_over_bump");
        apply_stimulus(I_START|I_CLIFF,  E_FAULT,  "fault_start_cliff");
        apply_stimulus(I_NONE,           E_FAULT,  "fault_hold");
        apply_stimulus(I_START,          E_SETTLE, "fault_restart");
        pause_into(E_SPST, "fault_to_spiral");
        apply_stimulus(I_SDONE|I_BUMP,   E_SETTLE, "done_and_bump");
        pause_into(E_TUST, "single_transition");
        apply_stimulus(I_STOP|I_BUMP,    E_IDLE,   "stop_over_bump");
        apply_stimulus(I_START|I_CLIFF,  E_FAULT,  "idle_start_cliff");
        apply_stimulus(I_START|I_STOP,   E_IDLE,   "fault_start_stop");
        apply_stimulus(I_START|I_STOP,   E_IDLE,   "idle_start_stop");
        apply_stimulus(I_START,          E_SETTLE, "start");
        apply_stimulus(I_TICK,           E_SETTLE, "pause1");
        apply_stimulus(I_STOP,           E_IDLE,   "settle_stop");
        apply_stimulus(I_START,          E_SETTLE, "restart");
        pause_into(E_SPST, "pause_cleared");
        apply_stimulus(I_SDONE,          E_SETTLE, "spiral_done");
        pause_into(E_TUST, "turn");
        apply_stimulus(I_TDONE,          E_RND,    "enter_rand");
        rand_run(50);

        // Asynchronous reset mid-RAND, away from any clock edge.
        {tick_en, start_btn, stop_btn, bump, cliff, spiral_done, turn_done} = I_NONE;
        rst = 1'b0;
        #2;
        check_output("reset_async", E_IDLE);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(I_NONE,  E_IDLE,   "post_reset_idle");
        apply_stimulus(I_START, E_SETTLE, "post_reset_start");
        pause_into(E_SPST, "post_reset_spiral");
        apply_stimulus(I_NONE,  E_SP,     "post_reset_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roam_mode_sequencer.md
Name: roam_mode_sequencer

Overview:
Sequences the robot's roaming behaviour by driving the 2-bit move-type select of the motion decision mux (pause / spiral / random). It also pulses start strobes to the spiral and random-motion generators. It is clocked off the system clock and advanced by a slow timebase tick. Bumps, cliffs and the user buttons change mode, with a settle pause inserted between every mode change.

Parameters:
PAUSE_TICKS, 4, ticks spent in pause between any two motion modes (>=1)
RAND_TICKS, 200, ticks of straight random motion per random segment (>=1)
RAND_SEGMENTS, 3, random segments completed before returning to spiral (>=1)
CNT_W, 8, width of tick counter; must hold max(PAUSE_TICKS, RAND_TICKS)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
tick_en  in  1  one-cycle timebase strobe; all tick counts advance only on it
start_btn  in  1  user start, level; sampled each clk
stop_btn  in  1  user stop, level
bump  in  1  bumper contact, already debounced
cliff  in  1  cliff sensor, already debounced
spiral_done  in  1  spiral generator reached max radius, one-cycle pulse
turn_done  in  1  random generator finished its turn-away, one-cycle pulse
move_type_mux  out  2  00 pause, 01 spiral, 10 random; 11 never driven
spiral_start  out  1  one-cycle pulse: restart spiral generator
rand_start  out  1  one-cycle pulse: start random turn-away
busy  out  1  high in every state except IDLE and FAULT
fault  out  1  high in FAULT

Behaviour:
- Reset (rst low, async): state IDLE, all counters 0, next_mode=SPIRAL, move_type_mux=00, spiral_start=0, rand_start=0, busy=0, fault=0.
- All outputs registered. Outputs are computed from the next state, so move_type_mux changes on the same edge as the state. Strobes are high for exactly the first cycle of the target state.
- States and mux encoding: IDLE(00), SETTLE(00), SPIRAL(01), TURN(10), RAND(10), FAULT(00).
- Event priority, evaluated every clk in all states except IDLE and FAULT: cliff > stop_btn > bump > done/timer events.
  - cliff: go to FAULT.
  - stop_btn: go to IDLE.
- IDLE: start_btn with cliff low -> SETTLE, next_mode=SPIRAL, seg_cnt=0. start_btn with cliff high -> FAULT.
- SETTLE:
  - tick_cnt increments on each tick_en.
  - On tick_en with tick_cnt==PAUSE_TICKS-1: clear tick_cnt and enter next_mode. Entering SPIRAL pulses spiral_start; entering TURN pulses rand_start.
  - bump in SETTLE is ignored; already paused.
- SPIRAL: bump or spiral_done -> SETTLE, next_mode=TURN, seg_cnt=0.
- TURN: turn_done -> RAND, tick_cnt=0. bump -> SETTLE, next_mode=TURN; seg_cnt unchanged.
- RAND:
  - tick_cnt increments on tick_en.
  - bump -> SETTLE, next_mode=TURN, seg_cnt+1.
  - Expiry is tick_en with tick_cnt==RAND_TICKS-1:
    - If seg_cnt==RAND_SEGMENTS-1: SETTLE, next_mode=SPIRAL, seg_cnt=0.
    - Otherwise: SETTLE, next_mode=TURN, seg_cnt+1.
  - bump and expiry in the same cycle: bump wins.
  - seg_cnt saturates at RAND_SEGMENTS-1. A bump at that value still routes to TURN; spiral is re-entered only by expiry.
- FAULT:
  - Holds mux 00, fault=1.
  - stop_btn -> IDLE.
  - start_btn with cliff low -> SETTLE, next_mode=SPIRAL, seg_cnt=0.
  - start_btn while cliff high is ignored.
- Simultaneous events:
  - spiral_done and bump together: single transition, as for bump.
  - start_btn and stop_btn together in IDLE or FAULT: stop wins; stay in or go to IDLE.
- tick_cnt clears on every state change. No counter wraps: compares are equality-terminated and the count clears on match.

Decomposition:
- Shared package roam_pkg:
  - MUX_PAUSE/MUX_SPIRAL/MUX_RAND encodings, shared with the decision mux.
  - State encoding constants.
- One natural sub-module: roam_tick_counter.
  - CNT_W counter with clear, tick-gated increment and terminal-match output.
  - Two instances: pause and random-run timing.
- seg_cnt and the FSM stay in the top level.

Test Plan:
- Reset mid-RAND, then release -> IDLE, mux=00, no strobes. start_btn -> mux 00 for 4 ticks, then mux=01 with spiral_start high exactly 1 cycle.
- SPIRAL, bump -> mux=00 same edge, 4 ticks later mux=10 with rand_start pulse. turn_done -> RAND. 200 ticks -> SETTLE.
- Three full RAND expiries (RAND_SEGMENTS=3) -> after the third, SETTLE then mux=01 with spiral_start; after the first two, TURN with rand_start.
- bump and RAND expiry same cycle -> next_mode=TURN. cliff asserted together with bump in SPIRAL -> FAULT, fault=1, mux=00.
- FAULT: start_btn while cliff=1 -> stays FAULT. cliff=0 + start_btn -> SETTLE, then SPIRAL. stop_btn+start_btn together -> IDLE.
- Bumps during SETTLE and missing tick_en -> state and counters hold. move_type_mux never observed as 11 (assertion across all tests).
